alu_seq: RTL
============

Name: alu_seq

Overview:
Multi-byte operation sequencer that drives the 8-bit ALU from the initiator side. It accepts one NBYTES-wide operation per valid/ready handshake and issues it to the ALU one byte per cycle, LSB byte first. For kADD it chains the ALU carry-out of each byte into the carry-in of the next. It collects the per-byte results and returns the wide result with final carry and aggregate zero flag on a response handshake.

Parameters:
NBYTES, 2, operand width in bytes (>=1); wide width W = 8*NBYTES

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accept
REQ_OP  in  4  ALU opcode (op_mne encoding)
REQ_A  in  W  operand A
REQ_B  in  W  operand B
REQ_CIN  in  1  carry-in for byte 0 (kADD only)
ALU_A  out  8  to ALU INPUTA
ALU_B  out  8  to ALU INPUTB
ALU_OP  out  4  to ALU OP
ALU_SC_IN  out  1  to ALU SC_IN
ALU_OUT  in  8  from ALU OUT
ALU_SC_OUT  in  1  from ALU SC_OUT
ALU_ZERO  in  1  from ALU ZERO
RSP_VALID  out  1  response valid
RSP_READY  in  1  response accept
RSP_RESULT  out  W  wide result
RSP_CARRY  out  1  SC_OUT of the last byte
RSP_ZERO  out  1  1 iff every byte result was zero

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RESET_N). Reset: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RESULT=0, RSP_CARRY=0, RSP_ZERO=0, byte index=0, latched op/operands=0.
- FSM states IDLE, ISSUE, DONE.
- IDLE: REQ_READY=1. REQ_VALID&REQ_READY latches op, A, B, CIN; goes to ISSUE, index=0, zero accumulator=1.
- ISSUE: REQ_READY=0. ALU_A/ALU_B = latched byte[index]; ALU_OP = latched op. The ALU is combinational, so its result is captured at the end of the same cycle into RSP_RESULT byte[index]. The zero accumulator ANDs in ALU_ZERO. The carry register takes ALU_SC_OUT.
- ALU_SC_IN: byte 0 = latched CIN if op==kADD, else 0. Bytes 1..N-1 = carry register if op==kADD, else 0.
- ISSUE moves to DONE after index==NBYTES-1. Otherwise index increments.
- DONE: RSP_VALID=1. RSP_CARRY = last ALU_SC_OUT; RSP_ZERO = accumulator. RSP_* stay stable until RSP_READY. On RSP_VALID&RSP_READY, goes to IDLE.
- Latency: accept at edge t; RSP_VALID high after edge t+NBYTES. Throughput: one op per NBYTES+2 cycles.
- Non-ADD ops (kXOR, kAND, kGBT, undefined) are applied bytewise with no chaining. Result is whatever the ALU returns per byte; undefined ops yield all-zero, RSP_ZERO=1.
- Outside ISSUE: ALU_A/ALU_B/ALU_OP hold latched values, ALU_SC_IN=0; ALU outputs are ignored.
- REQ_VALID while not ready: ignored, with no side effects.
- RESET_N low mid-ISSUE or mid-DONE: the operation is aborted and the block returns to reset values immediately.

Optional Feature:
ALU_SEQ_OVERLAP_EN
- Defined: in DONE, REQ_READY = RSP_READY. A request accepted in the same cycle the response drains goes directly to ISSUE, giving one op per NBYTES+1 cycles.
- Undefined: REQ_READY=0 in DONE, as above.

Decomposition:
- Package definitions holds:
  - op_mne enum (kADD, kXOR, kAND, kGBT), already shared with the ALU.
  - new seq_state_t enum {IDLE, ISSUE, DONE}.
- Byte index width is a local constant, $clog2(NBYTES) with a minimum of 1.
- No sub-module: single always_ff plus an always_comb for ALU drive. The bench instantiates the real ALU against ALU_* ports.

Test Plan:
- NBYTES=2, kADD A=16'h00FF B=16'h0001 CIN=0 -> RSP_RESULT=16'h0100, CARRY=0, ZERO=0; RSP_VALID exactly 2 edges after accept; ALU_SC_IN=1 in second ISSUE cycle.
- kADD A=16'hFFFF B=16'h0001 CIN=0 -> RESULT=16'h0000, CARRY=1, ZERO=1.
- kXOR A=16'hA5A5 B=16'hA5A5 CIN=1 -> RESULT=16'h0000, CARRY=0, ZERO=1; ALU_SC_IN=0 both ISSUE cycles.
- kADD A=16'h1234 B=16'h0001, RSP_READY held low 5 cycles -> RSP_VALID=1 and RESULT=16'h1235 stable throughout; REQ_READY=0; a REQ_VALID pulse is ignored.
- RESET_N pulled low during ISSUE byte 1 -> all outputs at reset values asynchronously; next kAND A=16'hF0F0 B=16'h0FF0 -> RESULT=16'h00F0, ZERO=0.
- With ALU_SEQ_OVERLAP_EN: two back-to-back kADDs with RSP_READY=1 -> second accepted in the DONE cycle of the first; responses 3 cycles apart.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the multi-byte ALU sequencer.
//   - op_mne      : 4-bit ALU opcode encoding, common with the 8-bit ALU.
//   - seq_state_t : sequencer FSM states.
//   - idx_width() : byte-index width helper ($clog2 with a floor of 1 bit).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [3:0] {
    kADD = 4'd0,
    kXOR = 4'd1,
    kAND = 4'd2,
    kGBT = 4'd3
  } op_mne;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // A single-byte sequencer still needs a 1-bit index so the declaration is legal.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Multi-byte operation sequencer driving an external combinational 8-bit ALU.
//   One NBYTES-wide operation is accepted per REQ handshake and issued to the
//   ALU one byte per cycle, LSB byte first. kADD chains the ALU carry-out of
//   each byte into the carry-in of the next; all other opcodes are bytewise.
//   The collected result, the last byte's carry and an aggregate zero flag are
//   returned on the RSP handshake.
//
// Parameters
//   NBYTES      operand width in bytes (>= 1); W = 8*NBYTES
//
// Ports
//   CLK, RESET_N                  clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY           request handshake
//   REQ_OP, REQ_A, REQ_B, REQ_CIN opcode, W-bit operands, byte-0 carry-in
//   ALU_A, ALU_B, ALU_OP          byte operands and opcode to the ALU
//   ALU_SC_IN                     carry into the ALU
//   ALU_OUT, ALU_SC_OUT, ALU_ZERO byte result, carry-out, zero from the ALU
//   RSP_VALID/RSP_READY           response handshake
//   RSP_RESULT, RSP_CARRY, RSP_ZERO wide result, last carry, all-bytes-zero
//
// Configuration macro
//   ALU_SEQ_OVERLAP_EN  when defined, a new request may be accepted in the
//                       same cycle the previous response drains (REQ_READY
//                       follows RSP_READY in DONE); otherwise REQ_READY is low
//                       in DONE.
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int NBYTES = 2,
  localparam int W      = 8 * NBYTES
) (
  input  logic         CLK,
  input  logic         RESET_N,
  // request
  input  logic         REQ_VALID,
  output logic         REQ_READY,
  input  logic [3:0]   REQ_OP,
  input  logic [W-1:0] REQ_A,
  input  logic [W-1:0] REQ_B,
  input  logic         REQ_CIN,
  // ALU drive / return
  output logic [7:0]   ALU_A,
  output logic [7:0]   ALU_B,
  output logic [3:0]   ALU_OP,
  output logic         ALU_SC_IN,
  input  logic [7:0]   ALU_OUT,
  input  logic         ALU_SC_OUT,
  input  logic         ALU_ZERO,
  // response
  output logic         RSP_VALID,
  input  logic         RSP_READY,
  output logic [W-1:0] RSP_RESULT,
  output logic         RSP_CARRY,
  output logic         RSP_ZERO
);

  localparam int              IDXW     = idx_width(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  seq_state_t                  state_q, state_d;
  logic [IDXW-1:0]             idx_q;
  logic [3:0]                  op_q;
  logic [NBYTES-1:0][7:0]      a_q;
  logic [NBYTES-1:0][7:0]      b_q;
  logic [NBYTES-1:0][7:0]      result_q;
  logic                        cin_q;
  logic                        carry_q;
  logic                        zacc_q;
  logic                        accept;

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; a missing default in combinational logic infers a latch.
  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    unique case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_d = ISSUE;
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        RSP_VALID = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
        REQ_READY = RSP_READY;
`else
        REQ_READY = 1'b0;
`endif
        // A request taken while the response drains skips IDLE entirely.
        if (RSP_READY) state_d = (REQ_VALID && REQ_READY) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = REQ_VALID && REQ_READY;

  // ---------------------------------------------------------------------------
  // ALU drive
  // ---------------------------------------------------------------------------
  // Operands always reflect the latched byte under the index; only the carry
  // input is gated, so the ALU sees a quiet carry outside ISSUE and for
  // non-add opcodes.
  always_comb begin
    ALU_A     = a_q[idx_q];
    ALU_B     = b_q[idx_q];
    ALU_OP    = op_q;
    ALU_SC_IN = 1'b0;
    if ((state_q == ISSUE) && (op_q == kADD)) begin
      ALU_SC_IN = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the operand and result registers are reset along with control state
  // so RSP_RESULT and the ALU drive come out of reset at a known zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= REQ_OP;
        a_q    <= REQ_A;
        b_q    <= REQ_B;
        cin_q  <= REQ_CIN;
        idx_q  <= '0;
        zacc_q <= 1'b1;
      end else if (state_q == ISSUE) begin
        // The ALU is combinational: its answer for this byte is ready now.
        result_q[idx_q] <= ALU_OUT;
        zacc_q          <= zacc_q & ALU_ZERO;
        carry_q         <= ALU_SC_OUT;
        if (idx_q != LAST_IDX) idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign RSP_RESULT = result_q;
  assign RSP_CARRY  = carry_q;
  assign RSP_ZERO   = zacc_q;

endmodule
